// File: rtl/oled_spi_receiver_if.sv
// Pin bundle of the OLED PMOD link: the interface master drives it, the SSD1331-side receiver samples it.
interface oled_spi_receiver_if;
  logic CS;
  logic MOSI;
  logic SCK;
  logic DC;
  logic RES;

  modport master (output CS, MOSI, SCK, DC, RES);
  modport slave  (input  CS, MOSI, SCK, DC, RES);
endinterface

// File: rtl/oled_spi_receiver.sv
// SSD1331-side receiver for the OLED PMOD link: pin sync, byte assembly, command decode, pixel addressing.
// Define OLED_RX_FRAME_CHECK_EN to flag CS deassertion with a partial byte on o_FRAME_ERR.
module oled_spi_receiver #(
  parameter int NUM_COL      = 96,
  parameter int NUM_ROW      = 64,
  parameter int N_COLOR_BITS = 8,
  parameter int SYNC_STAGES  = 2,
  localparam int CW = $clog2(NUM_COL),
  localparam int RW = $clog2(NUM_ROW)
) (
  input  logic                    i_CLK,
  input  logic                    i_RST,
  oled_spi_receiver_if.slave      i_pins,
  output logic [7:0]              o_BYTE,
  output logic                    o_BYTE_DC,
  output logic                    o_BYTE_VALID,
  output logic [7:0]              o_CMD,
  output logic                    o_CMD_VALID,
  output logic [CW-1:0]           o_PIX_COL,
  output logic [RW-1:0]           o_PIX_ROW,
  output logic [N_COLOR_BITS-1:0] o_PIX_DATA,
  output logic                    o_PIX_VALID,
  output logic                    o_DISPLAY_ON,
  output logic                    o_FRAME_ERR
);

  typedef enum logic [1:0] {S_IDLE, S_ARGS, S_PIXEL_READY} state_t;

  function automatic logic [3:0] arg_count(input logic [7:0] op);
    case (op)
      8'h15, 8'h75: arg_count = 4'd2;
      8'h21:        arg_count = 4'd7;
      8'h22:        arg_count = 4'd10;
      8'h25:        arg_count = 4'd4;
      8'h26, 8'h81, 8'h82, 8'h83, 8'h87, 8'h8A, 8'h8B, 8'h8C, 8'hA0,
      8'hA1, 8'hA2, 8'hA8, 8'hAD, 8'hB0, 8'hB1, 8'hB3, 8'hBB, 8'hBE:
                    arg_count = 4'd1;
      default:      arg_count = 4'd0;
    endcase
  endfunction

  function automatic logic [CW-1:0] clamp_col(input logic [7:0] a);
    if (int'(a) >= NUM_COL) return CW'(NUM_COL - 1);
    return CW'(a);
  endfunction

  function automatic logic [RW-1:0] clamp_row(input logic [7:0] a);
    if (int'(a) >= NUM_ROW) return RW'(NUM_ROW - 1);
    return RW'(a);
  endfunction

  // Lines packed as {CS, MOSI, SCK, DC, RES}; idle level has CS and RES high.
  logic [4:0] r_sync [SYNC_STAGES];
  logic [4:0] r_line;
  logic       r_sck_d;
  logic       w_cs, w_mosi, w_dc, w_res_n, w_sck_rise;

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= 5'b10001;
      r_line  <= 5'b10001;
      r_sck_d <= 1'b0;
    end else begin
      r_sync[0] <= {i_pins.CS, i_pins.MOSI, i_pins.SCK, i_pins.DC, i_pins.RES};
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_line  <= r_sync[SYNC_STAGES-1];
      r_sck_d <= r_line[2];
    end
  end

  assign w_cs       = r_line[4];
  assign w_mosi     = r_line[3];
  assign w_dc       = r_line[1];
  assign w_res_n    = r_line[0];
  assign w_sck_rise = r_line[2] & ~r_sck_d;

  logic [6:0] r_shift;
  logic [2:0] r_bit_cnt;
  logic [7:0] r_byte;
  logic       r_byte_dc, r_byte_valid;

  // CS high takes priority over a coincident SCK rise.
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      r_shift <= '0; r_bit_cnt <= '0; r_byte <= '0; r_byte_dc <= 1'b0; r_byte_valid <= 1'b0;
    end else if (!w_res_n) begin
      r_shift <= '0; r_bit_cnt <= '0; r_byte <= '0; r_byte_dc <= 1'b0; r_byte_valid <= 1'b0;
    end else begin
      r_byte_valid <= 1'b0;
      if (w_cs) begin
        r_bit_cnt <= '0;
      end else if (w_sck_rise) begin
        r_shift   <= {r_shift[5:0], w_mosi};
        r_bit_cnt <= r_bit_cnt + 3'd1;
        if (r_bit_cnt == 3'd7) begin
          r_byte       <= {r_shift, w_mosi};
          r_byte_dc    <= w_dc;
          r_byte_valid <= 1'b1;
        end
      end
    end
  end

`ifdef OLED_RX_FRAME_CHECK_EN
  logic r_cs_d, r_frame_err;
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      r_cs_d <= 1'b1; r_frame_err <= 1'b0;
    end else begin
      r_cs_d <= w_cs;
      if (!w_res_n) r_frame_err <= 1'b0;
      else if (w_cs && !r_cs_d && r_bit_cnt != 3'd0) r_frame_err <= 1'b1;
    end
  end
  assign o_FRAME_ERR = r_frame_err;
`else
  assign o_FRAME_ERR = 1'b0;
`endif

  state_t                  r_state;
  logic [7:0]              r_op, r_arg_prev, r_cmd;
  logic [3:0]              r_args_left;
  logic [CW-1:0]           r_col_start, r_col_end, r_col, r_pix_col;
  logic [RW-1:0]           r_row_start, r_row_end, r_row, r_pix_row;
  logic [N_COLOR_BITS-1:0] r_pix_data;
  logic                    r_cmd_valid, r_pix_valid, r_display_on;
  logic [CW-1:0]           w_col_s, w_col_e;
  logic [RW-1:0]           w_row_s, w_row_e;

  // Window candidates from the two address arguments (previous arg = start, current byte = end).
  always_comb begin
    w_col_s = clamp_col(r_arg_prev);
    w_col_e = clamp_col(r_byte);
    w_row_s = clamp_row(r_arg_prev);
    w_row_e = clamp_row(r_byte);
    if (w_col_e < w_col_s) w_col_e = w_col_s;
    if (w_row_e < w_row_s) w_row_e = w_row_s;
  end

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      r_state <= S_IDLE; r_op <= '0; r_arg_prev <= '0; r_args_left <= '0;
      r_col_start <= '0; r_col_end <= CW'(NUM_COL - 1); r_col <= '0;
      r_row_start <= '0; r_row_end <= RW'(NUM_ROW - 1); r_row <= '0;
      r_cmd <= '0; r_cmd_valid <= 1'b0; r_display_on <= 1'b0;
      r_pix_col <= '0; r_pix_row <= '0; r_pix_data <= '0; r_pix_valid <= 1'b0;
    end else if (!w_res_n) begin
      r_state <= S_IDLE; r_op <= '0; r_arg_prev <= '0; r_args_left <= '0;
      r_col_start <= '0; r_col_end <= CW'(NUM_COL - 1); r_col <= '0;
      r_row_start <= '0; r_row_end <= RW'(NUM_ROW - 1); r_row <= '0;
      r_cmd <= '0; r_cmd_valid <= 1'b0; r_display_on <= 1'b0;
      r_pix_col <= '0; r_pix_row <= '0; r_pix_data <= '0; r_pix_valid <= 1'b0;
    end else begin
      r_cmd_valid <= 1'b0;
      r_pix_valid <= 1'b0;
      if (r_byte_valid && r_byte_dc) begin
        r_pix_valid <= 1'b1;
        r_pix_col   <= r_col;
        r_pix_row   <= r_row;
        r_pix_data  <= N_COLOR_BITS'(r_byte);
        r_state     <= S_PIXEL_READY;
        if (r_col != r_col_end) begin
          r_col <= r_col + 1'b1;
        end else begin
          r_col <= r_col_start;
          r_row <= (r_row == r_row_end) ? r_row_start : r_row + 1'b1;
        end
      end else if (r_byte_valid && r_state == S_ARGS) begin
        r_arg_prev <= r_byte;
        if (r_args_left == 4'd1) begin
          r_cmd       <= r_op;
          r_cmd_valid <= 1'b1;
          r_state     <= S_IDLE;
          if (r_op == 8'h15) begin
            r_col_start <= w_col_s; r_col_end <= w_col_e; r_col <= w_col_s; r_row <= r_row_start;
          end else if (r_op == 8'h75) begin
            r_row_start <= w_row_s; r_row_end <= w_row_e; r_row <= w_row_s; r_col <= r_col_start;
          end
        end else begin
          r_args_left <= r_args_left - 4'd1;
        end
      end else if (r_byte_valid) begin
        r_op <= r_byte;
        if (arg_count(r_byte) == 4'd0) begin
          r_cmd       <= r_byte;
          r_cmd_valid <= 1'b1;
          r_state     <= S_IDLE;
          if (r_byte == 8'hAF) r_display_on <= 1'b1;
          if (r_byte == 8'hAE) r_display_on <= 1'b0;
        end else begin
          r_args_left <= arg_count(r_byte);
          r_state     <= S_ARGS;
        end
      end
    end
  end

  assign o_BYTE       = r_byte;
  assign o_BYTE_DC    = r_byte_dc;
  assign o_BYTE_VALID = r_byte_valid;
  assign o_CMD        = r_cmd;
  assign o_CMD_VALID  = r_cmd_valid;
  assign o_PIX_COL    = r_pix_col;
  assign o_PIX_ROW    = r_pix_row;
  assign o_PIX_DATA   = r_pix_data;
  assign o_PIX_VALID  = r_pix_valid;
  assign o_DISPLAY_ON = r_display_on;

endmodule

// File: tb/tb_oled_spi_receiver.sv
// Directed bench for oled_spi_receiver: serial bytes at SCK = clk/20, checked against hand-computed results.
module tb_oled_spi_receiver;
  localparam int CW = 7;
  localparam int RW = 6;
`ifdef OLED_RX_FRAME_CHECK_EN
  localparam logic EXP_FRAME = 1'b1;
`else
  localparam logic EXP_FRAME = 1'b0;
`endif

  logic          i_CLK = 1'b0;
  logic          i_RST;
  logic [7:0]    o_BYTE, o_CMD, o_PIX_DATA;
  logic          o_BYTE_DC, o_BYTE_VALID, o_CMD_VALID, o_PIX_VALID, o_DISPLAY_ON, o_FRAME_ERR;
  logic [CW-1:0] o_PIX_COL;
  logic [RW-1:0] o_PIX_ROW;

  oled_spi_receiver_if u_if ();

  oled_spi_receiver dut (
    .i_CLK        (i_CLK),
    .i_RST        (i_RST),
    .i_pins       (u_if),
    .o_BYTE       (o_BYTE),
    .o_BYTE_DC    (o_BYTE_DC),
    .o_BYTE_VALID (o_BYTE_VALID),
    .o_CMD        (o_CMD),
    .o_CMD_VALID  (o_CMD_VALID),
    .o_PIX_COL    (o_PIX_COL),
    .o_PIX_ROW    (o_PIX_ROW),
    .o_PIX_DATA   (o_PIX_DATA),
    .o_PIX_VALID  (o_PIX_VALID),
    .o_DISPLAY_ON (o_DISPLAY_ON),
    .o_FRAME_ERR  (o_FRAME_ERR)
  );

  always #5 i_CLK = ~i_CLK;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int t8 = 0;
  int n_byte = 0, n_cmd = 0, n_pix = 0;
  int last_byte_cyc = 0, last_cmd_cyc = 0;
  logic [7:0] last_cmd = 8'h00;
  int pq_col[$];
  int pq_row[$];
  int pq_dat[$];

  always @(posedge i_CLK) cyc <= cyc + 1;

  // Strobe monitor, sampled on the falling edge.
  always @(negedge i_CLK) begin
    if (o_BYTE_VALID) begin n_byte++; last_byte_cyc = cyc; end
    if (o_CMD_VALID) begin n_cmd++; last_cmd_cyc = cyc; last_cmd = o_CMD; end
    if (o_PIX_VALID) begin
      n_pix++;
      pq_col.push_back(int'(o_PIX_COL));
      pq_row.push_back(int'(o_PIX_ROW));
      pq_dat.push_back(int'(o_PIX_DATA));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge i_CLK);
  endtask

  task automatic send_bits(input logic [7:0] b, input logic dc, input int nbits);
    u_if.CS = 1'b0;
    u_if.DC = dc;
    for (int i = 0; i < nbits; i++) begin
      u_if.MOSI = b[7-i];
      u_if.SCK  = 1'b0;
      wait_clk(10);
      u_if.SCK  = 1'b1;
      if (i == 7) t8 = cyc + 1;
      wait_clk(10);
    end
    u_if.SCK = 1'b0;
    wait_clk(10);
  endtask

  task automatic cs_high();
    u_if.CS = 1'b1;
    wait_clk(10);
  endtask

  task automatic clear_pix();
    pq_col.delete(); pq_row.delete(); pq_dat.delete();
  endtask

  task automatic test_reset();
    logic [42:0] outs;
    int b0, c0, p0;
    wait_clk(3);
    outs = {o_BYTE, o_BYTE_DC, o_BYTE_VALID, o_CMD, o_CMD_VALID, o_PIX_COL, o_PIX_ROW,
            o_PIX_DATA, o_PIX_VALID, o_DISPLAY_ON, o_FRAME_ERR};
    vectors++;
    if (outs !== 43'd0) begin
      miscompares++; $display("FAIL reset_outputs: got %h expected 0", outs);
    end
    i_RST = 1'b0;
    wait_clk(5);
    b0 = n_byte; c0 = n_cmd; p0 = n_pix;
    send_bits(8'hA5, 1'b0, 8);
    vectors++;
    if (o_BYTE !== 8'hA5) begin miscompares++; $display("FAIL a5_byte: got %h expected a5", o_BYTE); end
    vectors++;
    if (o_BYTE_DC !== 1'b0) begin miscompares++; $display("FAIL a5_dc: got %b expected 0", o_BYTE_DC); end
    vectors++;
    if (n_byte - b0 !== 1) begin miscompares++; $display("FAIL a5_byte_strobes: got %0d expected 1", n_byte - b0); end
    vectors++;
    if (n_cmd - c0 !== 1) begin miscompares++; $display("FAIL a5_cmd_strobes: got %0d expected 1", n_cmd - c0); end
    vectors++;
    if (last_cmd !== 8'hA5) begin miscompares++; $display("FAIL a5_cmd: got %h expected a5", last_cmd); end
    vectors++;
    if (n_pix - p0 !== 0) begin miscompares++; $display("FAIL a5_no_pixel: got %0d expected 0", n_pix - p0); end
    vectors++;
    if (last_byte_cyc - t8 !== 3) begin
      miscompares++; $display("FAIL byte_latency: got %0d expected 3", last_byte_cyc - t8);
    end
    vectors++;
    if (last_cmd_cyc - t8 !== 4) begin
      miscompares++; $display("FAIL cmd_latency: got %0d expected 4", last_cmd_cyc - t8);
    end
  endtask

  task automatic test_window();
    int exp_c[7] = '{2, 3, 4, 2, 3, 4, 2};
    int exp_r[7] = '{1, 1, 1, 2, 2, 2, 1};
    int c0;
    c0 = n_cmd;
    send_bits(8'h15, 1'b0, 8); send_bits(8'h02, 1'b0, 8); send_bits(8'h04, 1'b0, 8);
    send_bits(8'h75, 1'b0, 8); send_bits(8'h01, 1'b0, 8); send_bits(8'h02, 1'b0, 8);
    vectors++;
    if (n_cmd - c0 !== 2 || last_cmd !== 8'h75) begin
      miscompares++; $display("FAIL window_cmds: got %0d strobes last %h expected 2 last 75", n_cmd - c0, last_cmd);
    end
    clear_pix();
    for (int i = 0; i < 7; i++) send_bits(8'(8'h10 + i), 1'b1, 8);
    vectors++;
    if (pq_col.size() !== 7) begin
      miscompares++; $display("FAIL window_pix_count: got %0d expected 7", pq_col.size());
    end else begin
      for (int i = 0; i < 7; i++) begin
        vectors++;
        if (pq_col[i] !== exp_c[i] || pq_row[i] !== exp_r[i] || pq_dat[i] !== 16 + i) begin
          miscompares++;
          $display("FAIL window_pix%0d: got (%0d,%0d) %h expected (%0d,%0d) %h",
                   i, pq_col[i], pq_row[i], pq_dat[i], exp_c[i], exp_r[i], 16 + i);
        end
      end
    end
  endtask

  task automatic test_clamp();
    int exp_r[3] = '{1, 2, 1};
    send_bits(8'h15, 1'b0, 8); send_bits(8'h70, 1'b0, 8); send_bits(8'h05, 1'b0, 8);
    clear_pix();
    for (int i = 0; i < 3; i++) send_bits(8'(8'h20 + i), 1'b1, 8);
    vectors++;
    if (pq_col.size() !== 3) begin
      miscompares++; $display("FAIL clamp_pix_count: got %0d expected 3", pq_col.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        vectors++;
        if (pq_col[i] !== 95 || pq_row[i] !== exp_r[i]) begin
          miscompares++;
          $display("FAIL clamp_pix%0d: got (%0d,%0d) expected (95,%0d)", i, pq_col[i], pq_row[i], exp_r[i]);
        end
      end
    end
  endtask

  task automatic test_frame_err();
    int b0;
    cs_high();
    b0 = n_byte;
    send_bits(8'hA8, 1'b0, 5);
    cs_high();
    send_bits(8'hAF, 1'b0, 8);
    vectors++;
    if (o_FRAME_ERR !== EXP_FRAME) begin
      miscompares++; $display("FAIL frame_err: got %b expected %b", o_FRAME_ERR, EXP_FRAME);
    end
    vectors++;
    if (n_byte - b0 !== 1 || o_BYTE !== 8'hAF) begin
      miscompares++; $display("FAIL partial_drop: got %0d bytes last %h expected 1 last af", n_byte - b0, o_BYTE);
    end
    vectors++;
    if (o_DISPLAY_ON !== 1'b1 || last_cmd !== 8'hAF) begin
      miscompares++; $display("FAIL display_on: got %b cmd %h expected 1 cmd af", o_DISPLAY_ON, last_cmd);
    end
  endtask

  task automatic test_abort();
    int c0;
    u_if.CS = 1'b1;
    i_RST = 1'b1;
    wait_clk(3);
    i_RST = 1'b0;
    wait_clk(5);
    clear_pix();
    c0 = n_cmd;
    send_bits(8'h81, 1'b0, 8);
    send_bits(8'h3C, 1'b1, 8);
    vectors++;
    if (n_cmd - c0 !== 0) begin miscompares++; $display("FAIL abort_no_cmd: got %0d expected 0", n_cmd - c0); end
    vectors++;
    if (pq_col.size() !== 1 || pq_col[0] !== 0 || pq_row[0] !== 0 || pq_dat[0] !== 8'h3C) begin
      miscompares++; $display("FAIL abort_pixel: got %0d pixels first (%0d,%0d) %h expected 1 (0,0) 3c",
                              pq_col.size(), pq_col[0], pq_row[0], pq_dat[0]);
    end
    send_bits(8'h55, 1'b1, 8);
    send_bits(8'hAF, 1'b0, 8);
    vectors++;
    if (pq_col.size() !== 2 || pq_col[1] !== 1 || pq_row[1] !== 0) begin
      miscompares++; $display("FAIL abort_next_pixel: got %0d pixels expected 2 with second at (1,0)", pq_col.size());
    end
    vectors++;
    if (n_cmd - c0 !== 1 || last_cmd !== 8'hAF) begin
      miscompares++; $display("FAIL abort_then_cmd: got %0d cmds last %h expected 1 last af", n_cmd - c0, last_cmd);
    end
  endtask

  task automatic test_res();
    logic [42:0] outs;
    int c0;
    send_bits(8'hAF, 1'b0, 8);
    send_bits(8'h22, 1'b0, 8); send_bits(8'h01, 1'b0, 8); send_bits(8'h02, 1'b0, 8);
    send_bits(8'hFF, 1'b0, 3);
    u_if.RES = 1'b0;
    wait_clk(10);
    outs = {o_BYTE, o_BYTE_DC, o_BYTE_VALID, o_CMD, o_CMD_VALID, o_PIX_COL, o_PIX_ROW,
            o_PIX_DATA, o_PIX_VALID, o_DISPLAY_ON, o_FRAME_ERR};
    vectors++;
    if (outs !== 43'd0) begin
      miscompares++; $display("FAIL res_outputs: got %h expected 0", outs);
    end
    u_if.CS = 1'b1;
    wait_clk(5);
    u_if.RES = 1'b1;
    wait_clk(10);
    c0 = n_cmd;
    clear_pix();
    send_bits(8'hAE, 1'b0, 8);
    vectors++;
    if (n_cmd - c0 !== 1 || last_cmd !== 8'hAE) begin
      miscompares++; $display("FAIL res_then_ae: got %0d cmds last %h expected 1 last ae", n_cmd - c0, last_cmd);
    end
    vectors++;
    if (o_DISPLAY_ON !== 1'b0 || o_FRAME_ERR !== 1'b0) begin
      miscompares++; $display("FAIL res_flags: got on=%b err=%b expected 0 0", o_DISPLAY_ON, o_FRAME_ERR);
    end
    send_bits(8'h77, 1'b1, 8);
    vectors++;
    if (pq_col.size() !== 1 || pq_col[0] !== 0 || pq_row[0] !== 0 || pq_dat[0] !== 8'h77) begin
      miscompares++; $display("FAIL res_pixel: got %0d pixels expected 1 at (0,0) data 77", pq_col.size());
    end
  endtask

  initial begin
    i_RST = 1'b1;
    u_if.CS = 1'b1; u_if.MOSI = 1'b0; u_if.SCK = 1'b0; u_if.DC = 1'b0; u_if.RES = 1'b1;
    test_reset();
    test_window();
    test_clamp();
    test_frame_err();
    test_abort();
    test_res();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
